// File: rtl/muxn_scan.sv
// muxn_scan -- N-channel data multiplexer with direct-select and auto-scan modes.
//
// Picks one W-bit channel out of a packed N-channel input bus and presents it
// as a registered beat on a valid/ready output. In direct mode the channel
// comes from sel. In scan mode an internal pointer walks the channels in
// ascending order and wraps. The pointer restarts at channel 0 on every
// direct-to-scan transition. A stalled beat (out_valid=1, out_ready=0) holds
// until it is accepted.
//
// Optional build feature:
//   MUXN_SCAN_MASK_EN  adds ch_mask; scan mode visits only the channels whose
//                      mask bit is set. With an all-zero mask, scan mode never
//                      loads a beat.
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = direct select, 1 = auto-scan
//   sel        channel select (direct mode only)
//   en         sample request
//   din        packed channels; channel k is din[k*W +: W]
//   ch_mask    per-channel scan enable (MUXN_SCAN_MASK_EN builds only)
//   out_ready  downstream accepts the current beat
//   dout       registered channel data
//   chan_out   channel index that dout came from
//   out_valid  beat on dout/chan_out/last/sel_err is valid
//   last       beat is the final enabled channel of a scan pass
//   sel_err    beat was taken with an out-of-range direct select
module muxn_scan #(
  parameter int N = 8,
  parameter int W = 1,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic            en,
  input  logic [N*W-1:0]  din,
`ifdef MUXN_SCAN_MASK_EN
  input  logic [N-1:0]    ch_mask,
`endif
  input  logic            out_ready,
  output logic [W-1:0]    dout,
  output logic [SW-1:0]   chan_out,
  output logic            out_valid,
  output logic            last,
  output logic            sel_err
);

  logic [N-1:0]  mask_s;
  logic          mode_prev_r;
  logic [SW-1:0] ptr_r;
  logic          reentry_s;
  logic [SW-1:0] eff_ptr_s;
  logic          hit_any_s;
  logic          hit_up_s;
  logic [SW-1:0] chan_any_s;
  logic [SW-1:0] chan_up_s;
  logic [SW-1:0] hi_chan_s;
  logic [SW-1:0] scan_chan_s;
  logic [SW-1:0] next_ptr_s;
  logic [SW-1:0] pick_chan_s;
  logic [W-1:0]  pick_data_s;
  logic          sel_ok_s;
  logic          pick_err_s;
  logic          pick_last_s;
  logic          load_s;

`ifdef MUXN_SCAN_MASK_EN
  assign mask_s = ch_mask;
`else
  assign mask_s = {N{1'b1}};
`endif

  // On the first scan cycle after direct mode, the search starts from channel 0
  // regardless of where the pointer was left.
  assign reentry_s = mode & ~mode_prev_r;
  assign eff_ptr_s = reentry_s ? {SW{1'b0}} : ptr_r;

  // Find the lowest enabled channel at or above the pointer, the lowest
  // enabled channel overall (wrap target), and the highest enabled channel
  // (end of pass). The descending loop lets the lowest index win.
  always_comb begin
    hit_any_s  = 1'b0;
    hit_up_s   = 1'b0;
    chan_any_s = {SW{1'b0}};
    chan_up_s  = {SW{1'b0}};
    hi_chan_s  = {SW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_s[k]) begin
        hit_any_s  = 1'b1;
        chan_any_s = SW'(k);
        if (SW'(k) >= eff_ptr_s) begin
          hit_up_s  = 1'b1;
          chan_up_s = SW'(k);
        end else begin
          hit_up_s  = hit_up_s;
        end
      end else begin
        hit_any_s = hit_any_s;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (mask_s[k]) begin
        hi_chan_s = SW'(k);
      end else begin
        hi_chan_s = hi_chan_s;
      end
    end
  end

  assign scan_chan_s = hit_up_s ? chan_up_s : chan_any_s;
  assign next_ptr_s  = (scan_chan_s == SW'(N - 1)) ? {SW{1'b0}} : (scan_chan_s + SW'(1));
  assign pick_chan_s = mode ? scan_chan_s : sel;

  // Channel data mux with constant part-selects only. A select with no
  // matching channel (sel >= N) leaves the data at zero.
  always_comb begin
    pick_data_s = {W{1'b0}};
    sel_ok_s    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (pick_chan_s == SW'(k)) begin
        pick_data_s = din[k*W +: W];
      end else begin
        pick_data_s = pick_data_s;
      end
      if (sel == SW'(k)) begin
        sel_ok_s = 1'b1;
      end else begin
        sel_ok_s = sel_ok_s;
      end
    end
  end

  assign pick_err_s  = ~mode & ~sel_ok_s;
  assign pick_last_s = mode & (scan_chan_s == hi_chan_s);

  // A beat loads when requested and the output slot is free or being drained.
  // In scan mode it also needs at least one enabled channel.
  assign load_s = en & (~out_valid | out_ready) & (~mode | hit_any_s);

  // Output beat register: load a new beat, retire an accepted one, or hold
  // under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= {W{1'b0}};
      chan_out  <= {SW{1'b0}};
      out_valid <= 1'b0;
      last      <= 1'b0;
      sel_err   <= 1'b0;
    end else if (load_s) begin
      dout      <= pick_data_s;
      chan_out  <= pick_chan_s;
      out_valid <= 1'b1;
      last      <= pick_last_s;
      sel_err   <= pick_err_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Scan pointer and previous-mode tracking. The pointer advances only on a
  // scan-mode load. A direct-to-scan transition with no load still rewinds
  // the pointer, so the next load starts from channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= {SW{1'b0}};
      mode_prev_r <= 1'b0;
    end else begin
      mode_prev_r <= mode;
      if (load_s && mode) begin
        ptr_r <= next_ptr_s;
      end else if (reentry_s) begin
        ptr_r <= {SW{1'b0}};
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_muxn_scan.sv
// Directed self-checking bench for muxn_scan: an 8-channel instance drives the
// main sequence, and a 6-channel instance covers out-of-range direct selects.
module tb_muxn_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mode;
  logic        en;
  logic        out_ready;
  logic [2:0]  sel;
  logic [63:0] din;
  logic [7:0]  dout;
  logic [2:0]  chan_out;
  logic        out_valid;
  logic        last;
  logic        sel_err;

  logic [2:0]  sel6;
  logic        en6;
  logic [47:0] din6;
  logic [7:0]  dout6;
  logic [2:0]  chan6;
  logic        valid6;
  logic        last6;
  logic        err6;

`ifdef MUXN_SCAN_MASK_EN
  logic [7:0]  ch_mask;
  logic [5:0]  ch_mask6;
`endif

  int errors = 0;
  int checks = 0;

  muxn_scan #(.N(8), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .en        (en),
    .din       (din),
`ifdef MUXN_SCAN_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_ready (out_ready),
    .dout      (dout),
    .chan_out  (chan_out),
    .out_valid (out_valid),
    .last      (last),
    .sel_err   (sel_err)
  );

  muxn_scan #(.N(6), .W(8)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (1'b0),
    .sel       (sel6),
    .en        (en6),
    .din       (din6),
`ifdef MUXN_SCAN_MASK_EN
    .ch_mask   (ch_mask6),
`endif
    .out_ready (1'b1),
    .dout      (dout6),
    .chan_out  (chan6),
    .out_valid (valid6),
    .last      (last6),
    .sel_err   (err6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat on the 8-channel instance: channel ch carries 0x10+ch.
  task automatic beat(input string tag, input int ch, input logic exp_last);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".chan"},  64'(chan_out),  64'(ch));
    chk({tag, ".dout"},  64'(dout),      64'(32'h10 + ch));
    chk({tag, ".last"},  64'(last),      64'(exp_last));
    chk({tag, ".err"},   64'(sel_err),   64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    en        = 1'b0;
    out_ready = 1'b1;
    sel       = 3'd0;
    sel6      = 3'd0;
    en6       = 1'b0;
    for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'(16 + k);
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'(16 + k);
`ifdef MUXN_SCAN_MASK_EN
    ch_mask  = 8'hFF;
    ch_mask6 = 6'h3F;
`endif

    #2;
    chk("rst.dout",  64'(dout),      64'd0);
    chk("rst.chan",  64'(chan_out),  64'd0);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.last",  64'(last),      64'd0);
    chk("rst.err",   64'(sel_err),   64'd0);
    chk("rst.valid6", 64'(valid6),   64'd0);

    step();
    step();
    rst_n = 1'b1;
    en    = 1'b1;
    sel   = 3'd5;
    en6   = 1'b1;
    sel6  = 3'd7;

    step();
    beat("direct5", 5, 1'b0);
    chk("range.dout",  64'(dout6),  64'd0);
    chk("range.err",   64'(err6),   64'd1);
    chk("range.chan",  64'(chan6),  64'd7);
    chk("range.valid", 64'(valid6), 64'd1);
    sel  = 3'd2;
    sel6 = 3'd5;

    step();
    beat("direct2", 2, 1'b0);
    chk("ok6.dout", 64'(dout6), 64'h15);
    chk("ok6.err",  64'(err6),  64'd0);
    chk("ok6.chan", 64'(chan6), 64'd5);
    en  = 1'b0;
    en6 = 1'b0;

    step();
    chk("drain.valid",  64'(out_valid), 64'd0);
    chk("drain.valid6", 64'(valid6),    64'd0);
    out_ready = 1'b0;
    en        = 1'b1;
    sel       = 3'd6;

    // Empty slot loads even with out_ready low; a later sel change waits.
    step();
    beat("emptyload", 6, 1'b0);
    sel = 3'd3;
    step();
    beat("stallsel", 6, 1'b0);
    out_ready = 1'b1;
    mode      = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      beat("scan", i % 8, (i % 8) == 7);
    end
    step();
    beat("scan2", 2, 1'b0);
    step();
    beat("scan3", 3, 1'b0);
    out_ready = 1'b0;
    sel       = 3'd7;

    for (int i = 0; i < 3; i++) begin
      step();
      beat("stall3", 3, 1'b0);
    end
    out_ready = 1'b1;
    step();
    beat("resume4", 4, 1'b0);

    mode = 1'b0;
    sel  = 3'd1;
    step();
    beat("direct1", 1, 1'b0);
    mode = 1'b1;
    step();
    beat("reentry0", 0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      step();
      beat("prerst", i, 1'b0);
    end

    // Pointer now sits at 5; assert reset between clock edges.
    rst_n = 1'b0;
    #1;
    chk("midrst.dout",  64'(dout),      64'd0);
    chk("midrst.chan",  64'(chan_out),  64'd0);
    chk("midrst.valid", 64'(out_valid), 64'd0);
    chk("midrst.last",  64'(last),      64'd0);
    chk("midrst.err",   64'(sel_err),   64'd0);
    step();
    rst_n = 1'b1;
    step();
    beat("postrst0", 0, 1'b0);
    step();
    beat("postrst1", 1, 1'b0);

`ifdef MUXN_SCAN_MASK_EN
    mode = 1'b0;
    sel  = 3'd0;
    step();
    beat("mdirect0", 0, 1'b0);
    ch_mask = 8'b1010_0100;
    mode    = 1'b1;
    step();
    beat("mask2", 2, 1'b0);
    step();
    beat("mask5", 5, 1'b0);
    step();
    beat("mask7", 7, 1'b1);
    step();
    beat("mask2b", 2, 1'b0);
    ch_mask = 8'h00;
    step();
    chk("mask0.valid", 64'(out_valid), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
